// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: boot sequencer and single-port arbiter for instruction memory.
// Optional fetch fairness under loader contention: define IMEM_ARB_FAIRNESS_EN.
module imem_port_arbiter #(
  parameter int DEPTH        = 32,
  parameter int MAX_LOAD_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  output logic        fetch_err,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        load_done,
  output logic        boot_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t state;
  logic   in_run;
  logic   force_fetch;
  logic   load_grant;
  logic   fetch_grant;
  logic   fetch_oob;

  assign in_run = (state == RUN);

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int CW = $clog2(MAX_LOAD_RUN) + 1;
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_LOAD_RUN);

  logic [CW-1:0] run_cnt;

  // Fetch steals the slot once the loader has won RUN_MAX contested cycles.
  assign force_fetch = in_run && fetch_valid && load_valid
                    && (run_cnt == RUN_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (!in_run || !fetch_valid || fetch_grant) begin
      run_cnt <= '0;
    end else if (load_grant) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_max_run;
  assign unused_max_run = 32'(MAX_LOAD_RUN);
  assign force_fetch    = 1'b0;
`endif

  assign load_grant  = load_valid && !force_fetch;
  assign fetch_grant = in_run && fetch_valid
                    && (!load_valid || force_fetch);
  assign fetch_oob   = (fetch_addr >= DEPTH_W);

  assign load_ready  = load_grant;
  assign fetch_ready = fetch_grant;

  assign mem_addr  = load_grant ? load_addr : fetch_addr;
  assign mem_wdata = load_data;
  assign mem_we    = load_grant && (load_addr < DEPTH_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      boot_busy    <= 1'b1;
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
      fetch_err    <= 1'b0;
    end else begin
      fetch_rvalid <= fetch_grant;
      fetch_err    <= fetch_grant && fetch_oob;
      if (fetch_grant) begin
        fetch_rdata <= fetch_oob ? '0 : mem_rdata;
      end
      unique case (state)
        BOOT: begin
          if (load_done) begin
            state     <= RUN;
            boot_busy <= 1'b0;
          end
        end
        RUN: begin
          state     <= RUN;
          boot_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: vector table, directed corner sequences and a
// randomized run checked against a rule-level model of the arbiter.
module tb_imem_port_arbiter;

  localparam int DEPTH = 32;
  localparam int MAXR  = 4;
  localparam logic [31:0] DEPTH_W = 32'd32;
`ifdef IMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        boot_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter #(.DEPTH(DEPTH), .MAX_LOAD_RUN(MAXR)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .boot_busy(boot_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'h0000_0013 + 32'(i) * 32'h0001_0100;
  endfunction

  // Instruction memory attached to the DUT port
  logic [31:0] dmem [DEPTH];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
    end else if (mem_we) begin
      dmem[mem_addr[4:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[4:0]];

  // Reference model
  logic [31:0] ref_mem [DEPTH];
  bit          m_run;
  int          m_cnt;
  bit          m_rv;
  bit          m_err;
  logic [31:0] m_rd;

  int checks = 0;
  int errors = 0;
  logic a_fr, a_lr, a_we;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic fv, input logic [31:0] fa,
                       input logic lv, input logic [31:0] la,
                       input logic [31:0] ld, input logic done,
                       input logic rst);
    bit contested, ffair, e_fr, e_lr, e_we;
    fetch_valid = fv;
    fetch_addr  = fa;
    load_valid  = lv;
    load_addr   = la;
    load_data   = ld;
    load_done   = done;
    reset       = rst;
    contested = m_run && fv && lv;
    ffair     = FAIR && contested && (m_cnt == MAXR);
    e_lr      = lv && !ffair;
    e_fr      = m_run && fv && (!lv || ffair);
    e_we      = e_lr && (la < DEPTH_W);
    @(negedge clk);
    a_fr = fetch_ready;
    a_lr = load_ready;
    a_we = mem_we;
    chk("fetch_ready", 32'(fetch_ready), 32'(e_fr));
    chk("load_ready", 32'(load_ready), 32'(e_lr));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_lr) begin
      chk("mem_addr_load", mem_addr, la);
      chk("mem_wdata", mem_wdata, ld);
    end else if (e_fr) begin
      chk("mem_addr_fetch", mem_addr, fa);
    end
    @(posedge clk);
    if (e_we) ref_mem[la[4:0]] = ld;
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      m_rv  = 1'b0;
      m_err = 1'b0;
      m_rd  = '0;
    end else begin
      m_rv  = e_fr;
      m_err = e_fr && (fa >= DEPTH_W);
      if (e_fr) m_rd = (fa < DEPTH_W) ? ref_mem[fa[4:0]] : 32'h0;
      if (!m_run || !fv || e_fr) m_cnt = 0;
      else if (contested) m_cnt = m_cnt + 1;
      if (!m_run && done) m_run = 1'b1;
    end
    #1;
    chk("boot_busy", 32'(boot_busy), 32'(!m_run));
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(m_rv));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    if (m_rv || rst) chk("fetch_rdata", fetch_rdata, m_rd);
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic        done;
    logic        e_fr;
    logic        e_lr;
    logic        e_we;
    logic        e_busy;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input logic fv, input logic [31:0] fa,
                              input logic lv, input logic [31:0] la,
                              input logic [31:0] ld, input logic done,
                              input logic e_fr, input logic e_lr,
                              input logic e_we, input logic e_busy,
                              input logic e_rv, input logic e_err,
                              input logic [31:0] e_rd);
    vec_t v;
    v.fv = fv; v.fa = fa; v.lv = lv; v.la = la; v.ld = ld;
    v.done = done; v.e_fr = e_fr; v.e_lr = e_lr; v.e_we = e_we;
    v.e_busy = e_busy; v.e_rv = e_rv; v.e_err = e_err; v.e_rd = e_rd;
    return v;
  endfunction

  initial begin
    bit exp_f;
    for (int i = 0; i < 5; i++)
      vt[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[5]  = mk(1, 0, 1, 1, 32'h00108093, 1, 0, 1, 1, 0, 0, 0, 0);
    vt[6]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h00108093);
    vt[7]  = mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, init_val(2));
    vt[8]  = mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, init_val(3));
    vt[9]  = mk(0, 0, 1, 40, 32'hdeadbeef, 0, 0, 1, 0, 0, 0, 0, 0);
    vt[10] = mk(1, 32, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    vt[11] = mk(0, 0, 1, 5, 32'hffdff1ef, 0, 0, 1, 1, 0, 0, 0, 0);
    vt[12] = mk(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'hffdff1ef);
    vt[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    m_run = 0; m_cnt = 0; m_rv = 0; m_err = 0; m_rd = '0;

    reset = 1'b1; init_mem = 1'b1;
    fetch_valid = 0; fetch_addr = '0; load_valid = 0;
    load_addr = '0; load_data = '0; load_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(fetch_rvalid), 32'h0);
    chk("rst_rdata", fetch_rdata, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_busy", 32'(boot_busy), 32'h1);
    init_mem = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cycle(vt[i].fv, vt[i].fa, vt[i].lv, vt[i].la, vt[i].ld,
            vt[i].done, 1'b0);
      chk($sformatf("v%0d_fready", i), 32'(a_fr), 32'(vt[i].e_fr));
      chk($sformatf("v%0d_lready", i), 32'(a_lr), 32'(vt[i].e_lr));
      chk($sformatf("v%0d_we", i), 32'(a_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_busy", i), 32'(boot_busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d_rvalid", i), 32'(fetch_rvalid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d_err", i), 32'(fetch_err), 32'(vt[i].e_err));
      if (vt[i].e_rv)
        chk($sformatf("v%0d_rdata", i), fetch_rdata, vt[i].e_rd);
    end

    // Sustained contention: fetch only gets slots with the fairness option
    for (int i = 0; i < 10; i++) begin
      cycle(1, 7, 1, 8, $urandom, 0, 0);
      exp_f = FAIR && (i == 4 || i == 9);
      chk($sformatf("cont%0d_fetch", i), 32'(a_fr), 32'(exp_f));
      chk($sformatf("cont%0d_load", i), 32'(a_lr), 32'(!exp_f));
    end
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Reset during an accepted fetch drops the response and re-enters boot
    cycle(1, 2, 0, 0, 0, 0, 1);
    chk("mid_rst_grant", 32'(a_fr), 32'h1);
    chk("mid_rst_rvalid", 32'(fetch_rvalid), 32'h0);
    chk("mid_rst_busy", 32'(boot_busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2, 0, 0, 0, 0, 0);
      chk($sformatf("stall%0d", i), 32'(a_fr), 32'h0);
    end
    cycle(1, 2, 0, 0, 0, 1, 0);
    cycle(1, 2, 0, 0, 0, 0, 0);
    chk("reboot_fetch", 32'(a_fr), 32'h1);

    // A write accepted under reset still lands in memory
    cycle(0, 0, 1, 6, 32'hcafef00d, 0, 1);
    chk("rst_write_we", 32'(a_we), 32'h1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(1, 6, 0, 0, 0, 0, 0);
    chk("rst_write_read", fetch_rdata, 32'hcafef00d);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 40)),
            $urandom_range(0, 2) == 0, 32'($urandom_range(0, 40)),
            $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 60) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
